// File: rtl/load_store_unit.sv
// Data-memory access stage: turns controller load/store codes into a req/ack
// bus transaction with byte enables, and returns extended load data. Stalls
// the core from the accept cycle until the one-cycle completion pulse.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [1:0]  mem_write,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] LT_LW  = 3'd1;
  localparam logic [2:0] LT_LB  = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       type_q;
  logic [1:0]       off_q;
  logic             is_store, is_load, accept, misalign, timeout_hit;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd1:    return 4'b0001 << off;
      2'd2:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd1:    return {4{d[7:0]}};
      2'd2:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] ltype, input logic [1:0] off,
                                              input logic [31:0] word);
    logic        [7:0]  bu;
    logic        [15:0] hu;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic signed [31:0] r;
    bu = word[{off, 3'b000} +: 8];
    hu = off[1] ? word[31:16] : word[15:0];
    bs = bu;
    hs = hu;
    case (ltype)
      LT_LW:   r = word;
      LT_LB:   r = 32'(bs);
      LT_LH:   r = 32'(hs);
      LT_LBU:  r = {24'd0, bu};
      LT_LHU:  r = {16'd0, hu};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Decode the presented op: store wins, undefined load codes count as none
  always_comb begin
    is_store    = (mem_write != 2'd0);
    is_load     = !is_store && (load_type inside {LT_LW, LT_LB, LT_LH, LT_LBU, LT_LHU});
    accept      = op_valid && (is_store || is_load);
    if (is_store)
      misalign = ((mem_write == 2'd2) && addr[0]) ||
                 ((mem_write == 2'd3) && (addr[1:0] != 2'd0));
    else
      misalign = ((load_type == LT_LW) && (addr[1:0] != 2'd0)) ||
                 (((load_type == LT_LH) || (load_type == LT_LHU)) && addr[0]);
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = misalign ? DONE : REQ;
      REQ:     if (dbus_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bus signals, captured op fields, timeout counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      type_q     <= '0;
      off_q      <= '0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      load_data  <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          type_q <= is_store ? 3'd0 : load_type;
          off_q  <= addr[1:0];
          cnt_q  <= '0;
          if (misalign) begin
            misaligned <= 1'b1;
            load_data  <= '0;
          end else begin
            dbus_we    <= is_store;
            dbus_addr  <= {addr[31:2], 2'b00};
            dbus_be    <= is_store ? store_be(mem_write, addr[1:0]) : 4'b1111;
            dbus_wdata <= is_store ? store_data(mem_write, wdata) : '0;
          end
        end
        REQ: begin
          if (dbus_ack || timeout_hit) begin
            load_data  <= dbus_ack ? extend_load(type_q, off_q, dbus_rdata) : '0;
            bus_err    <= !dbus_ack;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= '0;
            dbus_wdata <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          load_data  <= '0;
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dbus_req = (state_q == REQ);
  assign done     = (state_q == DONE);
  assign stall    = (state_q == REQ) || ((state_q == IDLE) && accept);

endmodule
